// File: rtl/nabp_swap_control_pkg.sv
// Shared constants and types for the NABP double-buffer swap sequencer.
// The iteration space is angle (outer) by line count (inner).
package nabp_swap_control_pkg;

  localparam int unsigned kAngleLength   = 8;
  localparam int unsigned kPEWidthLength = 4;
  localparam int unsigned kNoOfAngles    = 180;
  localparam int unsigned kNoOfLines     = 4;

  // The counter must be able to hold N itself, the saturated "all issued" value.
  function automatic int unsigned cnt_width(input int unsigned n_items);
    return $clog2(n_items + 1);
  endfunction

  localparam int unsigned kNoOfItems = kNoOfAngles * kNoOfLines;
  localparam int unsigned kCntWidth  = cnt_width(kNoOfItems);

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

  function automatic side_e other_side(input side_e s);
    return (s == SIDE_A) ? SIDE_B : SIDE_A;
  endfunction

endpackage

// File: rtl/nabp_swap_control_if.sv
// Per-side link between the sequencer (master) and one NABP state control (slave).
interface nabp_swap_control_if
  import nabp_swap_control_pkg::*;
#(
  parameter int unsigned ANGLE_W = kAngleLength,
  parameter int unsigned LINE_W  = kPEWidthLength
) ();

  logic              next_itr;
  logic              swap_ready;
  logic [ANGLE_W-1:0] angle;
  logic [LINE_W-1:0]  line_cnt;
  logic              itr_valid;
  logic              swap;

  modport master (
    input  next_itr, swap_ready,
    output angle, line_cnt, itr_valid, swap
  );

  modport slave (
    output next_itr, swap_ready,
    input  angle, line_cnt, itr_valid, swap
  );

endinterface

// File: rtl/nabp_itr_counter.sv
// Saturating item counter over (angle, line_cnt); exposes item k and k+1 so two
// simultaneous requests can be served in one cycle.
module nabp_itr_counter
  import nabp_swap_control_pkg::*;
#(
  parameter int unsigned ANGLE_W   = kAngleLength,
  parameter int unsigned LINE_W    = kPEWidthLength,
  parameter int unsigned NO_ANGLES = kNoOfAngles,
  parameter int unsigned NO_LINES  = kNoOfLines
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         i_advance,
  output logic [ANGLE_W-1:0] o_cur_angle,
  output logic [LINE_W-1:0]  o_cur_line,
  output logic               o_cur_valid,
  output logic [ANGLE_W-1:0] o_nxt_angle,
  output logic [LINE_W-1:0]  o_nxt_line,
  output logic               o_nxt_valid,
  output logic               o_at_end
);

  localparam int unsigned        N         = NO_ANGLES * NO_LINES;
  localparam int unsigned        CNT_W     = cnt_width(N);
  localparam logic [CNT_W-1:0]   N_CNT     = CNT_W'(N);
  localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(N - 1);
  localparam logic [LINE_W-1:0]  LAST_LINE = LINE_W'(NO_LINES - 1);

  typedef struct packed {
    logic [ANGLE_W-1:0] angle;
    logic [LINE_W-1:0]  line_cnt;
  } item_t;

  function automatic item_t step_item(input item_t it);
    item_t res;
    res = it;
    if (it.line_cnt == LAST_LINE) begin
      res.line_cnt = '0;
      res.angle    = it.angle + ANGLE_W'(1);
    end else begin
      res.line_cnt = it.line_cnt + LINE_W'(1);
    end
    return res;
  endfunction

  logic [CNT_W-1:0] r_cnt;
  item_t            r_item;
  logic [CNT_W-1:0] w_cnt_n;
  item_t            w_item_n;
  item_t            w_nxt_item;
  logic             w_cur_valid;
  logic             w_nxt_valid;
  logic             w_step1;
  logic             w_step2;

  assign w_nxt_item  = step_item(r_item);
  assign w_cur_valid = (r_cnt < N_CNT);
  // Compared against N-1 rather than cnt+1 < N so the sum never wraps CNT_W.
  assign w_nxt_valid = w_cur_valid && (r_cnt != LAST_CNT);
  assign w_step1     = (i_advance != 2'd0) && w_cur_valid;
  assign w_step2     = (i_advance == 2'd2) && w_nxt_valid;

  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    w_cnt_n  = r_cnt;
    w_item_n = r_item;
    if (w_step2) begin
      w_cnt_n  = r_cnt + CNT_W'(2);
      w_item_n = step_item(w_nxt_item);
    end else if (w_step1) begin
      w_cnt_n  = r_cnt + CNT_W'(1);
      w_item_n = w_nxt_item;
    end
  end

  // NOTE: sequential state uses <= so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_item <= '0;
    end else begin
      r_cnt  <= w_cnt_n;
      r_item <= w_item_n;
    end
  end

  assign o_cur_angle = r_item.angle;
  assign o_cur_line  = r_item.line_cnt;
  assign o_cur_valid = w_cur_valid;
  assign o_nxt_angle = w_nxt_item.angle;
  assign o_nxt_line  = w_nxt_item.line_cnt;
  assign o_nxt_valid = w_nxt_valid;
  assign o_at_end    = (r_cnt == N_CNT);

endmodule

// File: rtl/nabp_swap_control.sv
// Double-buffer sequencer: hands items to sides A/B on request and issues
// alternating swap pulses so exactly one side shifts at a time.
module nabp_swap_control
  import nabp_swap_control_pkg::*;
#(
  parameter int unsigned ANGLE_W   = kAngleLength,
  parameter int unsigned LINE_W    = kPEWidthLength,
  parameter int unsigned NO_ANGLES = kNoOfAngles,
  parameter int unsigned NO_LINES  = kNoOfLines
) (
  input  logic                clk,
  input  logic                reset,
  nabp_swap_control_if.master side_a,
  nabp_swap_control_if.master side_b,
  output logic                o_shift_sel,
  output logic                o_done
);

  typedef struct packed {
    logic [ANGLE_W-1:0] angle;
    logic [LINE_W-1:0]  line_cnt;
    logic               valid;
    logic               swap;
    logic               shifting;
  } side_t;

  logic [1:0]         w_advance;
  logic [ANGLE_W-1:0] w_cur_angle, w_nxt_angle;
  logic [LINE_W-1:0]  w_cur_line, w_nxt_line;
  logic               w_cur_valid, w_nxt_valid, w_at_end;

  side_t r_a, r_b, w_a_n, w_b_n;
  side_e r_turn, w_turn_n;
  side_e r_shift_sel, w_sel_n;
  logic  r_done, w_done_n;
  logic  w_turn_ready, w_swap_go, w_all_drained;

  assign w_advance = 2'(side_a.next_itr) + 2'(side_b.next_itr);

  nabp_itr_counter #(
    .ANGLE_W  (ANGLE_W),
    .LINE_W   (LINE_W),
    .NO_ANGLES(NO_ANGLES),
    .NO_LINES (NO_LINES)
  ) u_itr_counter (
    .clk        (clk),
    .reset      (reset),
    .i_advance  (w_advance),
    .o_cur_angle(w_cur_angle),
    .o_cur_line (w_cur_line),
    .o_cur_valid(w_cur_valid),
    .o_nxt_angle(w_nxt_angle),
    .o_nxt_line (w_nxt_line),
    .o_nxt_valid(w_nxt_valid),
    .o_at_end   (w_at_end)
  );

  // The turn side always holds the lowest unshifted item; an in-flight pulse
  // blocks a second swap before the shifting flag is visible.
  assign w_turn_ready  = (r_turn == SIDE_A) ? (side_a.swap_ready & r_a.valid)
                                            : (side_b.swap_ready & r_b.valid);
  assign w_swap_go     = w_turn_ready & ~r_a.shifting & ~r_b.shifting
                       & ~r_a.swap & ~r_b.swap & ~r_done;
  assign w_all_drained = w_at_end & ~r_a.valid & ~r_b.valid
                       & ~r_a.shifting & ~r_b.shifting;

  always_comb begin
    w_a_n      = r_a;
    w_b_n      = r_b;
    w_a_n.swap = 1'b0;
    w_b_n.swap = 1'b0;
    w_turn_n   = r_turn;
    w_sel_n    = r_shift_sel;
    w_done_n   = r_done | w_all_drained;

    if (side_a.next_itr) begin
      w_a_n.shifting = 1'b0;
      w_a_n.valid    = w_cur_valid;
      if (w_cur_valid) begin
        w_a_n.angle    = w_cur_angle;
        w_a_n.line_cnt = w_cur_line;
      end
    end

    // With a simultaneous request A takes item k, so B takes k+1.
    if (side_b.next_itr) begin
      w_b_n.shifting = 1'b0;
      if (side_a.next_itr) begin
        w_b_n.valid = w_nxt_valid;
        if (w_nxt_valid) begin
          w_b_n.angle    = w_nxt_angle;
          w_b_n.line_cnt = w_nxt_line;
        end
      end else begin
        w_b_n.valid = w_cur_valid;
        if (w_cur_valid) begin
          w_b_n.angle    = w_cur_angle;
          w_b_n.line_cnt = w_cur_line;
        end
      end
    end

    if (w_swap_go) begin
      if (r_turn == SIDE_A) begin
        w_a_n.swap     = 1'b1;
        w_a_n.shifting = 1'b1;
      end else begin
        w_b_n.swap     = 1'b1;
        w_b_n.shifting = 1'b1;
      end
      w_sel_n  = r_turn;
      w_turn_n = other_side(r_turn);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_turn      <= SIDE_A;
      r_shift_sel <= SIDE_A;
      r_done      <= 1'b0;
    end else begin
      r_a         <= w_a_n;
      r_b         <= w_b_n;
      r_turn      <= w_turn_n;
      r_shift_sel <= w_sel_n;
      r_done      <= w_done_n;
    end
  end

  assign side_a.angle     = r_a.angle;
  assign side_a.line_cnt  = r_a.line_cnt;
  assign side_a.itr_valid = r_a.valid;
  assign side_a.swap      = r_a.swap;
  assign side_b.angle     = r_b.angle;
  assign side_b.line_cnt  = r_b.line_cnt;
  assign side_b.itr_valid = r_b.valid;
  assign side_b.swap      = r_b.swap;
  assign o_shift_sel      = r_shift_sel;
  assign o_done           = r_done;

endmodule

// File: tb/tb_nabp_swap_control.sv
// Scoreboard bench: stimulus queues expected events, a negedge monitor pops and
// compares them as the DUTs present issues, swap pulses and done.
module tb_nabp_swap_control;
  import nabp_swap_control_pkg::*;

  typedef enum int {EV_ISSUE_A, EV_ISSUE_B, EV_SWAP_A, EV_SWAP_B, EV_DONE} ev_kind_e;

  typedef struct {
    ev_kind_e kind;
    int       angle;
    int       line;
    int       valid;
    int       sel;
  } ev_t;

  typedef struct {
    logic rst, na, nb;
    int   a_angle, a_line, a_valid, a_swap;
    int   b_angle, b_line, b_valid, b_swap;
    int   sel, done;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic sel0, done0, sel1, done1;

  nabp_swap_control_if ia0 ();
  nabp_swap_control_if ib0 ();
  nabp_swap_control_if ia1 ();
  nabp_swap_control_if ib1 ();

  nabp_swap_control #(.NO_ANGLES(2), .NO_LINES(2)) dut0 (
    .clk(clk), .reset(rst0), .side_a(ia0), .side_b(ib0),
    .o_shift_sel(sel0), .o_done(done0)
  );

  nabp_swap_control #(.NO_ANGLES(3), .NO_LINES(1)) dut1 (
    .clk(clk), .reset(rst1), .side_a(ia1), .side_b(ib1),
    .o_shift_sel(sel1), .o_done(done1)
  );

  ev_t q0[$];
  ev_t q1[$];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  prev_na[2];
  bit  prev_nb[2];
  bit  prev_done[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input ev_kind_e k, input int a = 0, input int l = 0,
                             input int v = 0, input int s = 0);
    ev_t e;
    e.kind = k; e.angle = a; e.line = l; e.valid = v; e.sel = s;
    return e;
  endfunction

  task automatic consume(input int d, input ev_t got);
    ev_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_checks++;
      n_errors++;
      $display("FAIL dut%0d unexpected event: got %s expected none", d, got.kind.name());
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    check($sformatf("dut%0d_ev_kind(exp %s)", d, e.kind.name()), got.kind, e.kind);
    if (got.kind == e.kind) begin
      case (e.kind)
        EV_ISSUE_A, EV_ISSUE_B: begin
          check($sformatf("dut%0d_%s_angle", d, e.kind.name()), got.angle, e.angle);
          check($sformatf("dut%0d_%s_line", d, e.kind.name()), got.line, e.line);
          check($sformatf("dut%0d_%s_valid", d, e.kind.name()), got.valid, e.valid);
        end
        EV_SWAP_A, EV_SWAP_B:
          check($sformatf("dut%0d_%s_shift_sel", d, e.kind.name()), got.sel, e.sel);
        default: ;
      endcase
    end
  endtask

  task automatic scan(input int d, input obs_t o);
    if (o.rst) begin
      prev_na[d] = 1'b0; prev_nb[d] = 1'b0; prev_done[d] = 1'b0;
      return;
    end
    if (prev_na[d]) consume(d, mk(EV_ISSUE_A, o.a_angle, o.a_line, o.a_valid));
    if (prev_nb[d]) consume(d, mk(EV_ISSUE_B, o.b_angle, o.b_line, o.b_valid));
    if (o.a_swap != 0) consume(d, mk(EV_SWAP_A, 0, 0, 0, o.sel));
    if (o.b_swap != 0) consume(d, mk(EV_SWAP_B, 0, 0, 0, o.sel));
    if (o.done != 0 && !prev_done[d]) consume(d, mk(EV_DONE));
    prev_na[d]   = o.na;
    prev_nb[d]   = o.nb;
    prev_done[d] = (o.done != 0);
  endtask

  always @(negedge clk) begin
    obs_t o0, o1;
    o0 = '{rst0, ia0.next_itr, ib0.next_itr,
           int'(ia0.angle), int'(ia0.line_cnt), int'(ia0.itr_valid), int'(ia0.swap),
           int'(ib0.angle), int'(ib0.line_cnt), int'(ib0.itr_valid), int'(ib0.swap),
           int'(sel0), int'(done0)};
    o1 = '{rst1, ia1.next_itr, ib1.next_itr,
           int'(ia1.angle), int'(ia1.line_cnt), int'(ia1.itr_valid), int'(ia1.swap),
           int'(ib1.angle), int'(ib1.line_cnt), int'(ib1.itr_valid), int'(ib1.swap),
           int'(sel1), int'(done1)};
    scan(0, o0);
    scan(1, o1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse0(input bit a, input bit b);
    ia0.next_itr = a; ib0.next_itr = b;
    tick(1);
    ia0.next_itr = 1'b0; ib0.next_itr = 1'b0;
  endtask

  task automatic pulse1(input bit a, input bit b);
    ia1.next_itr = a; ib1.next_itr = b;
    tick(1);
    ia1.next_itr = 1'b0; ib1.next_itr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ia0.next_itr = 0; ia0.swap_ready = 0; ib0.next_itr = 0; ib0.swap_ready = 0;
    ia1.next_itr = 0; ia1.swap_ready = 0; ib1.next_itr = 0; ib1.swap_ready = 0;
    tick(3);

    check("rst_a_valid", 32'(ia0.itr_valid), 0);
    check("rst_a_angle", 32'(ia0.angle), 0);
    check("rst_a_line", 32'(ia0.line_cnt), 0);
    check("rst_b_valid", 32'(ib0.itr_valid), 0);
    check("rst_a_swap", 32'(ia0.swap), 0);
    check("rst_b_swap", 32'(ib0.swap), 0);
    check("rst_shift_sel", 32'(sel0), 0);
    check("rst_done", 32'(done0), 0);
    rst0 = 1'b0;
    tick(1);

    // Full N=4 run: simultaneous first request, then strict A/B alternation.
    q0.push_back(mk(EV_ISSUE_A, 0, 0, 1));
    q0.push_back(mk(EV_ISSUE_B, 0, 1, 1));
    pulse0(1, 1);

    q0.push_back(mk(EV_SWAP_A, 0, 0, 0, 0));
    ia0.swap_ready = 1; ib0.swap_ready = 1;
    tick(3);
    ia0.swap_ready = 0;
    tick(17);

    q0.push_back(mk(EV_ISSUE_A, 1, 0, 1));
    q0.push_back(mk(EV_SWAP_B, 0, 0, 0, 1));
    pulse0(1, 0);
    tick(4);
    ib0.swap_ready = 0;

    q0.push_back(mk(EV_ISSUE_B, 1, 1, 1));
    q0.push_back(mk(EV_SWAP_A, 0, 0, 0, 0));
    ia0.swap_ready = 1;
    pulse0(0, 1);
    tick(4);
    ia0.swap_ready = 0;

    q0.push_back(mk(EV_ISSUE_A, 1, 0, 0));
    q0.push_back(mk(EV_SWAP_B, 0, 0, 0, 1));
    ib0.swap_ready = 1;
    pulse0(1, 0);
    tick(4);
    ib0.swap_ready = 0;

    q0.push_back(mk(EV_ISSUE_B, 1, 1, 0));
    q0.push_back(mk(EV_DONE));
    pulse0(0, 1);
    check("done_not_yet", 32'(done0), 0);
    tick(1);
    check("done_rise", 32'(done0), 1);
    ia0.swap_ready = 1; ib0.swap_ready = 1;
    tick(10);
    ia0.swap_ready = 0; ib0.swap_ready = 0;
    check("done_sticky", 32'(done0), 1);

    // Restart, bring B into shifting, then abort with an asynchronous reset.
    rst0 = 1'b1;
    tick(2);
    rst0 = 1'b0;
    tick(1);
    q0.push_back(mk(EV_ISSUE_A, 0, 0, 1));
    q0.push_back(mk(EV_ISSUE_B, 0, 1, 1));
    pulse0(1, 1);
    q0.push_back(mk(EV_SWAP_A, 0, 0, 0, 0));
    ia0.swap_ready = 1;
    tick(3);
    ia0.swap_ready = 0;
    q0.push_back(mk(EV_ISSUE_A, 1, 0, 1));
    q0.push_back(mk(EV_SWAP_B, 0, 0, 0, 1));
    ib0.swap_ready = 1;
    pulse0(1, 0);
    tick(4);
    ib0.swap_ready = 0;
    check("pre_abort_shift_sel", 32'(sel0), 1);
    #2;
    rst0 = 1'b1;
    #1;
    check("abort_a_valid", 32'(ia0.itr_valid), 0);
    check("abort_b_valid", 32'(ib0.itr_valid), 0);
    check("abort_a_angle", 32'(ia0.angle), 0);
    check("abort_b_line", 32'(ib0.line_cnt), 0);
    check("abort_shift_sel", 32'(sel0), 0);
    check("abort_done", 32'(done0), 0);
    tick(2);
    rst0 = 1'b0;
    tick(1);
    q0.push_back(mk(EV_ISSUE_A, 0, 0, 1));
    pulse0(1, 0);
    tick(3);

    // N=3: simultaneous request at cnt=N-1 leaves B invalid and never swapped.
    rst1 = 1'b0;
    tick(1);
    q1.push_back(mk(EV_ISSUE_A, 0, 0, 1));
    pulse1(1, 0);
    q1.push_back(mk(EV_ISSUE_A, 1, 0, 1));
    pulse1(1, 0);
    q1.push_back(mk(EV_ISSUE_A, 2, 0, 1));
    q1.push_back(mk(EV_ISSUE_B, 0, 0, 0));
    pulse1(1, 1);
    q1.push_back(mk(EV_SWAP_A, 0, 0, 0, 0));
    ia1.swap_ready = 1; ib1.swap_ready = 1;
    tick(3);
    ia1.swap_ready = 0;
    q1.push_back(mk(EV_ISSUE_A, 2, 0, 0));
    q1.push_back(mk(EV_DONE));
    pulse1(1, 0);
    tick(12);
    ib1.swap_ready = 0;
    check("n3_done", 32'(done1), 1);
    check("n3_b_valid", 32'(ib1.itr_valid), 0);

    for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) tick(1);
    check("dut0_events_pending", 32'(q0.size()), 0);
    check("dut1_events_pending", 32'(q1.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nabp_swap_control.md
Name: nabp_swap_control

Overview:
Upstream sequencer for a pair of NABP state controls, side A and side B, run as a double buffer: one side fills while the other shifts. It walks the iteration space (angle outer, line count inner) and hands one (angle, line_cnt) item to whichever side requests it. It issues per-side swap pulses in strict alternation and drives the shifter-path select. It raises done once every item has been shifted.

Parameters:
kAngleLength, 8, width of angle fields
kPEWidthLength, 4, width of line_cnt fields
kNoOfAngles, 180, angles per sweep; angle runs 0..kNoOfAngles-1
kNoOfLines, 4, line counts per angle; line_cnt runs 0..kNoOfLines-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
a_next_itr  in  1  side A requests the next item (high for one cycle)
a_swap_ready  in  1  side A has finished filling
b_next_itr  in  1  side B requests the next item
b_swap_ready  in  1  side B has finished filling
a_angle  out  kAngleLength  item angle for side A
a_line_cnt  out  kPEWidthLength  item line count for side A
a_itr_valid  out  1  side A holds a real item
a_swap  out  1  one-cycle swap pulse to side A
b_angle, b_line_cnt, b_itr_valid, b_swap  out  same widths  side B equivalents
shift_sel  out  1  side currently shifting: 0 = A, 1 = B
done  out  1  all items shifted; sticky until reset

Behaviour:
- Reset (asynchronous): item counter 0, all angle/line_cnt outputs 0, itr_valid 0, swap 0, shifting flags 0, turn = A, shift_sel 0, done 0.
- N = kNoOfAngles*kNoOfLines items. Item k maps to angle = k / kNoOfLines and line_cnt = k % kNoOfLines. The counter saturates at N.
- Item issue: next_itr high in cycle t updates that side's outputs at the edge ending cycle t, so they are stable in cycle t+1, the consumer's setup cycle.
  - Issued item = current counter value; itr_valid = (cnt < N); cnt increments if < N.
  - If itr_valid = 0, the angle and line_cnt outputs hold their old values.
- Simultaneous a_next_itr and b_next_itr: A gets k, B gets k+1, counter advances by up to 2. Each side's itr_valid is computed separately; near N, B may be invalid while A is valid.
- Shifting flags: shifting_X is set when X_swap is issued and cleared on X_next_itr.
- Swap rule, evaluated each cycle for turn side T and other side O. Condition: T_swap_ready & T_itr_valid & !shifting_O & !shifting_T & no swap pulse in flight. When it holds, X_swap is a registered one-cycle pulse in the next cycle, and at the same edge shifting_T is set, shift_sel becomes T, and turn toggles.
- Only one side is ever shifting. A side never receives a second swap pulse before its next_itr.
- A side holding an invalid item is never swapped. Turn order follows item order, so the turn side always holds the lowest unshifted item.
- done rises at the edge after cnt == N & !a_itr_valid & !b_itr_valid & !shifting_A & !shifting_B. After done, no swap pulses are issued.
- A next_itr arriving while its side is already shifting is still honoured (item issue), and it clears the shift flag.
- swap_ready while it is not that side's turn is ignored until the turn arrives.
- Reset mid-operation aborts everything immediately. No item is replayed.

Decomposition:
- Shared package holds kAngleLength, kPEWidthLength, kNoOfAngles, kNoOfLines, the side encoding (A = 0, B = 1), and the derived N and counter width.
- Sub-module nabp_itr_counter: saturating item counter with split angle/line_cnt outputs. It takes an advance-by-0/1/2 input and outputs the current and next items plus their valid flags.
- The swap/turn logic stays in the top level.

Test Plan:
- kNoOfAngles=2, kNoOfLines=2: reset, then a_next_itr and b_next_itr together -> next cycle A=(angle 0, line 0, valid), B=(angle 0, line 1, valid).
- Both sides swap_ready after the first issue -> a_swap pulses for one cycle, shift_sel=0; b_swap stays 0 until A's next_itr, then b_swap pulses and shift_sel=1.
- Full run, N=4 -> swaps alternate A,B,A,B; items issued in order (0,0),(0,1),(1,0),(1,1); done rises one cycle after the last shifting side's next_itr; no fifth swap.
- N=3 (kNoOfAngles=3, kNoOfLines=1) with simultaneous requests at the end -> the final requester gets itr_valid=0 and is never swapped; done asserts.
- Hold b_swap_ready high for 20 cycles while A is shifting -> no b_swap pulse until a_next_itr; exactly one b_swap pulse after it.
- Assert reset mid-shift -> all outputs return to reset values within the same cycle (asynchronous); after release, the sequence restarts at item 0.
